// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode/funct constants, state encoding and ALU codes for the multicycle control
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - combinational ALU control decode from aluop and funct
module alu_dec
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_AND;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_AND;
                endcase
            end
            default:   alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle MIPS control FSM with memory handshake and async reset
module mc_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       halt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] pcsrc,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [3:0] aluControl,
    output logic [3:0] state,
    output logic       illegal
);

    state_t     state_q;
    state_t     state_n;
    logic [5:0] op_q;

    // opcode is captured in DECODE so MEMADR picks lw/sw from the decoded instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= OP_RTYPE;
        end else begin
            state_q <= state_n;
            if (state_q == S_DECODE) op_q <= opcode;
        end
    end

    always_comb begin
        state_n = S_FETCH;
        case (state_q)
            S_FETCH:   state_n = (!halt && mem_ready) ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_EXECUTE;
                    OP_BEQ:       state_n = S_BRANCH;
                    OP_ADDI:      state_n = S_ADDIEX;
                    OP_J:         state_n = S_JUMP;
                    default:      state_n = S_FETCH;
                endcase
            end
            S_MEMADR:  state_n = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_n = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_n = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_n = S_ALUWB;
            S_ADDIEX:  state_n = S_ADDIWB;
            default:   state_n = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        pcsrc    = PCSRC_ALU;
        alusrcb  = SRCB_REG;
        aluop    = ALUOP_ADD;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!halt) begin
                    mem_req = 1'b1;
                    alusrcb = SRCB_FOUR;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
            end
            S_DECODE: begin
                alusrcb = SRCB_BRIMM;
                illegal = !is_legal_op(opcode);
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = mem_ready;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
                pcsrc   = PCSRC_OUT;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_ADDIWB:  regwrite = 1'b1;
            S_JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = PCSRC_JUMP;
            end
            default: ;
        endcase
        // reset silences every control immediately, even mid-access
        if (!rst_n) begin
            mem_req  = 1'b0;
            memwrite = 1'b0;
            iord     = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            regwrite = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            alusrca  = 1'b0;
            pcsrc    = PCSRC_ALU;
            alusrcb  = SRCB_REG;
            aluop    = ALUOP_ADD;
            illegal  = 1'b0;
        end
    end

    assign state = state_q;

    alu_dec u_alu_dec (
        .aluop       (aluop),
        .funct       (funct),
        .alu_control (aluControl)
    );

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - randomized scoreboard bench for mc_control against an instruction-level model
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       halt = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, memwrite, iord, irwrite, pcwrite, branch;
    logic       regwrite, regdst, memtoreg, alusrca, illegal;
    logic [1:0] pcsrc, alusrcb, aluop;
    logic [3:0] aluControl, state;

    mc_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .halt(halt),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite), .iord(iord),
        .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .pcsrc(pcsrc),
        .alusrcb(alusrcb), .aluop(aluop), .aluControl(aluControl), .state(state),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req, memwrite, iord, irwrite, pcwrite, branch;
        logic       regwrite, regdst, memtoreg, alusrca, illegal;
        logic [1:0] pcsrc, alusrcb, aluop;
        logic [3:0] alu_control;
    } ctl_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

    ctl_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic ctl_t base(input logic [3:0] s);
        ctl_t c = '0;
        c.state       = s;
        c.alu_control = 4'b0010;
        return c;
    endfunction

    function automatic logic [3:0] ref_alu(input logic [5:0] f);
        case (f)
            6'd32:   return 4'b0010;
            6'd34:   return 4'b0110;
            6'd36:   return 4'b0000;
            6'd37:   return 4'b0001;
            6'd42:   return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic ctl_t sample();
        ctl_t a;
        a.state = state;       a.mem_req = mem_req;   a.memwrite = memwrite;
        a.iord = iord;         a.irwrite = irwrite;   a.pcwrite = pcwrite;
        a.branch = branch;     a.regwrite = regwrite; a.regdst = regdst;
        a.memtoreg = memtoreg; a.alusrca = alusrca;   a.illegal = illegal;
        a.pcsrc = pcsrc;       a.alusrcb = alusrcb;   a.aluop = aluop;
        a.alu_control = aluControl;
        return a;
    endfunction

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic compare(input string name, input ctl_t act, input ctl_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s state %0d: got %h want %h", name, exp.state, act, exp);
        end
    endtask

    // monitor: one expected control vector per cycle, checked mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) compare("cycle", sample(), exp_q.pop_front());
        end
    end

    task automatic step(input ctl_t e, input logic r, input logic h, input logic rdy,
                        input logic [5:0] op, input logic [5:0] fn);
        @(posedge clk);
        #1;
        rst_n = r; halt = h; mem_ready = rdy; opcode = op; funct = fn;
        exp_q.push_back(e);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int hw,
                             input int fw, input int mw, input bit rst_in_memrd);
        ctl_t e;
        for (int i = 0; i < hw; i++) step(base(4'd0), 1, 1, rb(), junk(), junk());
        e = base(4'd0); e.mem_req = 1; e.alusrcb = 2'b01;
        for (int i = 0; i < fw; i++) step(e, 1, 0, 0, junk(), junk());
        e.irwrite = 1; e.pcwrite = 1;
        step(e, 1, 0, 1, junk(), junk());
        e = base(4'd1); e.alusrcb = 2'b11;
        e.illegal = !(op inside {LW, SW, RT, BEQ, ADDI, J});
        step(e, 1, rb(), rb(), op, junk());
        case (op)
            LW, SW: begin
                e = base(4'd2); e.alusrca = 1; e.alusrcb = 2'b10;
                step(e, 1, rb(), rb(), junk(), junk());
                e = base(op == LW ? 4'd3 : 4'd5); e.mem_req = 1; e.iord = 1;
                if (rst_in_memrd) begin
                    step(e, 1, rb(), 0, junk(), junk());
                    @(negedge clk);
                    #2 rst_n = 1'b0;
                    #1 compare("async_reset", sample(), base(4'd0));
                    step(base(4'd0), 0, rb(), rb(), junk(), junk());
                end else begin
                    for (int i = 0; i < mw; i++) step(e, 1, rb(), 0, junk(), junk());
                    if (op == SW) begin
                        e.memwrite = 1;
                        step(e, 1, rb(), 1, junk(), junk());
                    end else begin
                        step(e, 1, rb(), 1, junk(), junk());
                        e = base(4'd4); e.regwrite = 1; e.memtoreg = 1;
                        step(e, 1, rb(), rb(), junk(), junk());
                    end
                end
            end
            RT: begin
                e = base(4'd6); e.alusrca = 1; e.aluop = 2'b10; e.alu_control = ref_alu(fn);
                step(e, 1, rb(), rb(), junk(), fn);
                e = base(4'd7); e.regwrite = 1; e.regdst = 1;
                step(e, 1, rb(), rb(), junk(), junk());
            end
            BEQ: begin
                e = base(4'd8); e.alusrca = 1; e.aluop = 2'b01; e.branch = 1;
                e.pcsrc = 2'b01; e.alu_control = 4'b0110;
                step(e, 1, rb(), rb(), junk(), junk());
            end
            ADDI: begin
                e = base(4'd9); e.alusrca = 1; e.alusrcb = 2'b10;
                step(e, 1, rb(), rb(), junk(), junk());
                e = base(4'd10); e.regwrite = 1;
                step(e, 1, rb(), rb(), junk(), junk());
            end
            J: begin
                e = base(4'd11); e.pcwrite = 1; e.pcsrc = 2'b10;
                step(e, 1, rb(), rb(), junk(), junk());
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] fns [6];
        ops = '{LW, SW, RT, BEQ, ADDI, J, 6'd0};
        fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
        step(base(4'd0), 0, 0, 1, junk(), junk());
        step(base(4'd0), 0, 1, 1, junk(), junk());
        run_instr(LW, 6'd0, 0, 0, 0, 0);
        run_instr(SW, 6'd0, 0, 0, 2, 0);
        run_instr(RT, 6'd34, 0, 0, 0, 0);
        run_instr(RT, 6'd42, 0, 1, 0, 0);
        run_instr(BEQ, 6'd0, 0, 0, 0, 0);
        run_instr(J, 6'd0, 0, 0, 0, 0);
        run_instr(ADDI, 6'd0, 0, 2, 0, 0);
        run_instr(LW, 6'd0, 3, 0, 1, 0);
        run_instr(6'b111111, 6'd0, 0, 0, 0, 0);
        run_instr(LW, 6'd0, 0, 0, 0, 1);
        run_instr(RT, 6'd32, 0, 0, 0, 0);
        for (int n = 0; n < 300; n++) begin
            ops[6] = junk();
            fns[5] = junk();
            run_instr(ops[$urandom_range(0, 6)], fns[$urandom_range(0, 5)],
                      $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                      ($urandom_range(0, 19) == 0));
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have port clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port opcode  in  6  instr[31:26] from instruction register.
REQ-004 SHALL have port funct  in  6  instr[5:0].
REQ-005 SHALL have port halt  in  1  hold in FETCH, no fetch issued.
REQ-006 SHALL have port mem_ready  in  1  memory completes current access this cycle.
REQ-007 SHALL have port mem_req  out  1  memory access request.
REQ-008 SHALL have ports memwrite, iord, irwrite, pcwrite, branch, regwrite, regdst, memtoreg, alusrca  out  1 each  datapath controls.
REQ-009 SHALL have ports pcsrc, alusrcb, aluop  out  2 each; aluControl  out  4; state  out  4 (debug); illegal  out  1.

Function
REQ-010 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 go to FETCH next cycle with all enables 0.
REQ-011 SHALL decode opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
REQ-012 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=1 only in the cycle mem_ready=1; then DECODE; otherwise stay.
REQ-013 FETCH with halt=1: mem_req=0, no enables, stay; halt is ignored in all other states.
REQ-014 DECODE: alusrca=0, alusrcb=11, aluop=00; next lw/sw->MEMADR, R->EXECUTE, beq->BRANCH, addi->ADDIEX, j->JUMP; other opcode->FETCH with illegal=1 for that one cycle.
REQ-015 MEMADR: alusrca=1, alusrcb=10, aluop=00; lw->MEMRD, sw->MEMWR.
REQ-016 MEMRD: mem_req=1, iord=1; mem_ready=1 -> MEMWB, else stay.
REQ-017 MEMWB: regwrite=1, memtoreg=1, regdst=0; -> FETCH.
REQ-018 MEMWR: mem_req=1, iord=1, memwrite=1 only in mem_ready cycle; mem_ready=1 -> FETCH, else stay.
REQ-019 EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB; ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
REQ-020 BRANCH: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01 -> FETCH.
REQ-021 ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB; ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
REQ-022 JUMP: pcwrite=1, pcsrc=10 -> FETCH.
REQ-023 Every control not listed for a state SHALL be 0.
REQ-024 aluControl SHALL be combinational: aluop 00->0010, 01->0110, 10 by funct: 32->0010, 34->0110, 36->0000, 37->0001, 42->0111, other->0000; aluop 11->0000.
REQ-025 Zero-wait cycle counts SHALL be lw 5, sw 4, R 4, addi 4, beq 3, j 3; each mem_ready=0 cycle adds one.
REQ-026 opcode/funct SHALL be sampled only in DECODE/EXECUTE; changes elsewhere have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately force state=FETCH and every output 0 except aluControl=0010, including mid-access; no write enable is asserted during reset.
REQ-028 First cycle after rst_n rises SHALL be FETCH with mem_req=1 unless halt=1.

Structure
REQ-029 Shared package mips_pkg SHALL hold opcode/funct constants, state encoding, aluop and aluControl codes.
REQ-030 ALU control decode SHALL be sub-module alu_dec (aluop, funct -> aluControl); FSM stays in mc_control.

Verification
REQ-031 Reset then lw opcode, mem_ready=1 always -> states 0,1,2,3,4,0; regwrite=memtoreg=1 only in state 4.
REQ-032 sw with mem_ready low 2 cycles in MEMWR -> mem_req=1 three cycles, memwrite=1 only third cycle.
REQ-033 R-type funct=34 -> aluControl=0110 in EXECUTE, regwrite=regdst=1 in ALUWB; funct=42 -> 0111.
REQ-034 beq -> states 0,1,8,0, branch=1, pcsrc=01, aluop=01 in BRANCH; j -> pcwrite=1, pcsrc=10 in JUMP.
REQ-035 halt=1 three cycles in FETCH -> mem_req=0, state=0, no enables; opcode 111111 -> illegal=1 one cycle, back to FETCH.
REQ-036 rst_n pulsed low in MEMRD -> state=0, mem_req=0 asynchronously, no regwrite.
